// File: rtl/pipe_stage_skid.sv
// Pipeline-stage register with valid/ready handshake, flush, bubble defaults,
// optional two-entry skid buffer and saturating bubble/stall counters.
module pipe_stage_skid #(
  parameter int                CTRL_W       = 16,
  parameter int                DATA_W       = 112,
  parameter logic [CTRL_W-1:0] CTRL_DEFAULT = {CTRL_W{1'b0}},
  parameter logic [DATA_W-1:0] DATA_DEFAULT = {DATA_W{1'b0}},
  parameter int                SKID         = 1,
  parameter int                CNT_W        = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic              r_m_valid;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic [CNT_W-1:0]  r_bubble_cnt;
  logic [CNT_W-1:0]  r_stall_cnt;
  logic              w_in_ready;
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_out_xfer = r_m_valid & out_ready;
  assign w_in_xfer  = in_valid & w_in_ready;

  generate
    if (SKID != 0) begin : g_skid
      logic              r_s_valid;
      logic [CTRL_W-1:0] r_s_ctrl;
      logic [DATA_W-1:0] r_s_data;

      // S only fills while M is held, so a full S is the sole reason to refuse input.
      assign w_in_ready = ~r_s_valid;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_m_valid <= 1'b0;
          r_m_ctrl  <= CTRL_DEFAULT;
          r_m_data  <= DATA_DEFAULT;
          r_s_valid <= 1'b0;
          r_s_ctrl  <= CTRL_DEFAULT;
          r_s_data  <= DATA_DEFAULT;
        end else if (flush) begin
          r_m_valid <= 1'b0;
          r_s_valid <= 1'b0;
        end else if (!r_m_valid || w_out_xfer) begin
          if (r_s_valid) begin
            r_m_valid <= 1'b1;
            r_m_ctrl  <= r_s_ctrl;
            r_m_data  <= r_s_data;
            r_s_valid <= 1'b0;
          end else if (w_in_xfer) begin
            r_m_valid <= 1'b1;
            r_m_ctrl  <= in_ctrl;
            r_m_data  <= in_data;
          end else begin
            r_m_valid <= 1'b0;
          end
        end else if (w_in_xfer) begin
          r_s_valid <= 1'b1;
          r_s_ctrl  <= in_ctrl;
          r_s_data  <= in_data;
        end
      end
    end else begin : g_flop
      assign w_in_ready = ~r_m_valid | out_ready;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_m_valid <= 1'b0;
          r_m_ctrl  <= CTRL_DEFAULT;
          r_m_data  <= DATA_DEFAULT;
        end else if (flush) begin
          r_m_valid <= 1'b0;
        end else if (w_in_xfer) begin
          r_m_valid <= 1'b1;
          r_m_ctrl  <= in_ctrl;
          r_m_data  <= in_data;
        end else if (w_out_xfer) begin
          r_m_valid <= 1'b0;
        end
      end
    end
  endgenerate

  // Empty stage presents the safe defaults so no stale write enable escapes.
  assign in_ready  = w_in_ready;
  assign out_valid = r_m_valid;
  assign out_ctrl  = r_m_valid ? r_m_ctrl : CTRL_DEFAULT;
  assign out_data  = r_m_valid ? r_m_data : DATA_DEFAULT;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else if (cnt_clr) begin
      r_bubble_cnt <= '0;
      r_stall_cnt  <= '0;
    end else begin
      if (!r_m_valid && out_ready && (r_bubble_cnt != CNT_MAX))
        r_bubble_cnt <= r_bubble_cnt + CNT_ONE;
      if (r_m_valid && !out_ready && (r_stall_cnt != CNT_MAX))
        r_stall_cnt <= r_stall_cnt + CNT_ONE;
    end
  end

  assign bubble_cnt = r_bubble_cnt;
  assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: channel 0 is a skid stage with 4-bit counters,
// channel 1 a single-register stage with non-zero defaults; both track a FIFO model.
module tb_pipe_stage_skid;

  localparam logic [15:0]  DEF_C1 = 16'h8000;
  localparam logic [111:0] DEF_D1 = 112'h5A5A;

  typedef struct packed {
    logic [15:0]  c;
    logic [111:0] d;
  } ent_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         iv[2], irdy[2], fl[2], ov[2], ordy[2], clr[2];
  logic [15:0]  ic[2], oc[2];
  logic [111:0] id[2], od[2];
  logic [3:0]   bc0, sc0;
  logic [15:0]  bc1, sc1;

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(112), .SKID(1), .CNT_W(4)) u_skid (
    .clk(clk), .rst(rst),
    .in_valid(iv[0]), .in_ready(irdy[0]), .in_ctrl(ic[0]), .in_data(id[0]),
    .flush(fl[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]), .out_ctrl(oc[0]), .out_data(od[0]),
    .cnt_clr(clr[0]), .bubble_cnt(bc0), .stall_cnt(sc0)
  );

  pipe_stage_skid #(.CTRL_W(16), .DATA_W(112), .CTRL_DEFAULT(DEF_C1),
                    .DATA_DEFAULT(DEF_D1), .SKID(0), .CNT_W(16)) u_flop (
    .clk(clk), .rst(rst),
    .in_valid(iv[1]), .in_ready(irdy[1]), .in_ctrl(ic[1]), .in_data(id[1]),
    .flush(fl[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]), .out_ctrl(oc[1]), .out_data(od[1]),
    .cnt_clr(clr[1]), .bubble_cnt(bc1), .stall_cnt(sc1)
  );

  // Reference model: a FIFO of capacity 2 (skid) or 1 (single register).
  ent_t mq[2][2];
  int   mcnt[2];
  int   bub[2];
  int   stl[2];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [111:0] rnd_data();
    logic [127:0] t;
    t = {$urandom, $urandom, $urandom, $urandom};
    return t[111:0];
  endfunction

  function automatic int cmax(input int ch);
    return (ch == 0) ? 15 : 65535;
  endfunction

  function automatic logic exp_ready(input int ch);
    if (ch == 0) return (mcnt[0] < 2);
    return (mcnt[1] == 0) || ordy[1];
  endfunction

  function automatic logic [15:0] defc(input int ch);
    return (ch == 0) ? 16'h0 : DEF_C1;
  endfunction

  function automatic logic [111:0] defd(input int ch);
    return (ch == 0) ? 112'h0 : DEF_D1;
  endfunction

  function automatic int obs_bub(input int ch);
    return (ch == 0) ? int'(bc0) : int'(bc1);
  endfunction

  function automatic int obs_stl(input int ch);
    return (ch == 0) ? int'(sc0) : int'(sc1);
  endfunction

  task automatic check_outputs();
    for (int ch = 0; ch < 2; ch++) begin
      logic         ev;
      logic [15:0]  ec;
      logic [111:0] ed;
      ev = (mcnt[ch] != 0);
      ec = ev ? mq[ch][0].c : defc(ch);
      ed = ev ? mq[ch][0].d : defd(ch);
      check($sformatf("ch%0d out_valid", ch), 128'(ov[ch]), 128'(ev));
      check($sformatf("ch%0d out_ctrl", ch), 128'(oc[ch]), 128'(ec));
      check($sformatf("ch%0d out_data", ch), 128'(od[ch]), 128'(ed));
      check($sformatf("ch%0d in_ready", ch), 128'(irdy[ch]), 128'(exp_ready(ch)));
      check($sformatf("ch%0d bubble_cnt", ch), 128'(obs_bub(ch)), 128'(bub[ch]));
      check($sformatf("ch%0d stall_cnt", ch), 128'(obs_stl(ch)), 128'(stl[ch]));
    end
  endtask

  task automatic update_model();
    for (int ch = 0; ch < 2; ch++) begin
      logic push, pop;
      push = iv[ch] && exp_ready(ch);
      pop  = (mcnt[ch] != 0) && ordy[ch];
      if (clr[ch]) begin
        bub[ch] = 0;
        stl[ch] = 0;
      end else begin
        if (mcnt[ch] == 0 && ordy[ch] && bub[ch] < cmax(ch)) bub[ch]++;
        if (mcnt[ch] != 0 && !ordy[ch] && stl[ch] < cmax(ch)) stl[ch]++;
      end
      if (fl[ch]) begin
        mcnt[ch] = 0;
      end else begin
        if (pop) begin
          mq[ch][0] = mq[ch][1];
          mcnt[ch]--;
        end
        if (push) begin
          mq[ch][mcnt[ch]] = '{c: ic[ch], d: id[ch]};
          mcnt[ch]++;
        end
      end
    end
  endtask

  // Entered and left at posedge+1 with inputs already applied.
  task automatic cycle();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    #1;
    update_model();
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic r,
                       input logic f, input logic cl);
    for (int ch = 0; ch < 2; ch++) begin
      iv[ch]   = v;
      ic[ch]   = c;
      id[ch]   = rnd_data();
      ordy[ch] = r;
      fl[ch]   = f;
      clr[ch]  = cl;
    end
  endtask

  initial begin
    for (int ch = 0; ch < 2; ch++) begin
      mcnt[ch] = 0;
      bub[ch]  = 0;
      stl[ch]  = 0;
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Stream of four entries with downstream always ready.
    for (int k = 1; k <= 4; k++) begin
      drive(1'b1, 16'(k), 1'b1, 1'b0, 1'b0);
      cycle();
      if (k == 1) check("stream first bubble", 128'(bc0), 128'(1));
    end
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    // Skid fill while stalled, then drain in order.
    drive(1'b1, 16'hA, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hB, 1'b0, 1'b0, 1'b0);
    cycle();
    check("skid in_ready low", 128'(irdy[0]), 128'(0));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (3) cycle();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Flush with both entries held and a live input.
    drive(1'b1, 16'hC, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hD, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'hE, 1'b0, 1'b1, 1'b0);
    cycle();
    check("flush out_valid", 128'(ov[0]), 128'(0));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (2) cycle();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (2) cycle();

    // Single-register stage: combinational in_ready and replace-on-accept.
    drive(1'b1, 16'h11, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h12, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Stall counter saturation on the 4-bit channel, then clear.
    drive(1'b1, 16'h21, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    repeat (20) cycle();
    check("stall saturate", 128'(sc0), 128'(15));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    cycle();
    check("stall cleared", 128'(sc0), 128'(0));
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    repeat (3) cycle();

    // Asynchronous reset with the skid stage full.
    drive(1'b1, 16'h31, 1'b0, 1'b0, 1'b0);
    cycle();
    drive(1'b1, 16'h32, 1'b0, 1'b0, 1'b0);
    cycle();
    #2;
    rst = 1'b0;
    #1;
    for (int ch = 0; ch < 2; ch++) begin
      mcnt[ch] = 0;
      bub[ch]  = 0;
      stl[ch]  = 0;
    end
    check("async rst out_valid", 128'(ov[0]), 128'(0));
    check("async rst out_ctrl", 128'(oc[1]), 128'(DEF_C1));
    check("async rst out_data", 128'(od[1]), 128'(DEF_D1));
    check("async rst stall_cnt", 128'(sc0), 128'(0));
    drive(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    drive(1'b1, 16'h41, 1'b1, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
    cycle();
    check("post-reset first out", 128'(oc[0]), 128'(0));
    cycle();

    // Randomized traffic on both channels independently.
    repeat (1500) begin
      for (int ch = 0; ch < 2; ch++) begin
        iv[ch]   = ($urandom_range(0, 3) != 0);
        ic[ch]   = 16'($urandom);
        id[ch]   = rnd_data();
        ordy[ch] = ($urandom_range(0, 2) != 0);
        fl[ch]   = ($urandom_range(0, 31) == 0);
        clr[ch]  = ($urandom_range(0, 63) == 0);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
